// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared encodings and width defaults for the IF/D unified-memory arbiter.
package imem_dmem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_priority_sel.sv
// Combinational winner select between the IF and D requesters.
// ARB_ROUND_ROBIN_EN selects round-robin on ties; otherwise D always beats IF.
module arb_priority_sel
    import imem_dmem_arbiter_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  owner_t last_owner,
    output logic   grant,
    output owner_t winner
);

    assign grant = if_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        winner = d_req ? OWN_D : OWN_IF;
        // On a tie the port that was not served last goes first.
        if (if_req && d_req)
            winner = (last_owner == OWN_D) ? OWN_IF : OWN_D;
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
    assign winner = d_req ? OWN_D : OWN_IF;
`endif

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// one transaction in flight. Optional round-robin ties via ARB_ROUND_ROBIN_EN.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_t state;
    owner_t     owner;
    owner_t     last_owner;
    owner_t     winner;
    logic       grant;

    arb_priority_sel u_sel (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_owner (last_owner),
        .grant      (grant),
        .winner     (winner)
    );

`ifndef ARB_ROUND_ROBIN_EN
    assign last_owner = OWN_D;
`endif

    assign if_stall = if_req && !if_valid;
    assign d_stall  = d_req && !d_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= OWN_IF;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= OWN_D;
`endif
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner <= winner;
                        m_req <= 1'b1;
                        state <= ISSUE;
                        if (winner == OWN_D) begin
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                        end else begin
                            m_we   <= 1'b0;
                            m_addr <= if_addr;
                        end
                    end
                end
                ISSUE: begin
                    if (m_ready) begin
                        m_req <= 1'b0;
                        if (m_we) begin
                            state <= DONE;
                            if (owner == OWN_D) d_valid <= 1'b1;
                            else                if_valid <= 1'b1;
                        end else if (m_rvalid) begin
                            // Zero-latency read: data arrives with the accept.
                            state <= DONE;
                            if (owner == OWN_D) begin
                                d_rdata <= m_rdata;
                                d_valid <= 1'b1;
                            end else begin
                                if_rdata <= m_rdata;
                                if_valid <= 1'b1;
                            end
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (m_rvalid) begin
                        state <= DONE;
                        if (owner == OWN_D) begin
                            d_rdata <= m_rdata;
                            d_valid <= 1'b1;
                        end else begin
                            if_rdata <= m_rdata;
                            if_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner <= owner;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench: transaction scoreboard plus directed cycle-exact checks.
module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_valid, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_valid, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_ready, m_rvalid;
    logic [31:0] m_addr, m_wdata, m_rdata;

    imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit FIRST_D = 1'b0;
`else
    localparam bit FIRST_D = 1'b1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic failm(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a * 32'h0010_4208;
    endfunction

    // ---------------- memory environment ----------------
    logic [31:0] env_mem [logic [31:0]];
    int          rdy_knob = 0, rv_knob = 0, rdy_cnt = 0, rv_cnt = 0;
    bit          pend_rd = 0, spurious = 0;
    logic [31:0] pend_addr;

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : pat(a);
    endfunction

    task automatic set_mem(input int rdy, input int rv);
        rdy_knob = rdy;
        rdy_cnt  = rdy;
        rv_knob  = rv;
    endtask

    initial begin
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'hBAD0_BAD0;
        forever begin
            @(posedge clk); #1;
            m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'hBAD0_BAD0;
            if (spurious) begin
                m_rvalid = 1'b1; m_rdata = 32'h5555_AAAA; spurious = 0;
            end
            if (pend_rd) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    m_rvalid = 1'b1; m_rdata = env_rd(pend_addr); pend_rd = 0;
                end
            end
            if (m_req && !reset) begin
                if (rdy_cnt > 0) rdy_cnt--;
                else begin
                    m_ready = 1'b1;
                    rdy_cnt = rdy_knob;
                    if (m_we) env_mem[m_addr] = m_wdata;
                    else if (rv_knob == 0) begin
                        m_rvalid = 1'b1; m_rdata = env_rd(m_addr);
                    end else begin
                        pend_rd = 1; rv_cnt = rv_knob; pend_addr = m_addr;
                    end
                end
            end
        end
    end

    // ---------------- requesters ----------------
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } dreq_t;
    logic [31:0] if_pend[$];
    dreq_t       d_pend[$];

    initial begin
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                if_req = 1'b0; d_req = 1'b0;
                if_pend.delete(); d_pend.delete();
            end else begin
                if (if_valid && if_pend.size() > 0) begin
                    if_req = 1'b0; void'(if_pend.pop_front());
                end
                if (d_valid && d_pend.size() > 0) begin
                    d_req = 1'b0; void'(d_pend.pop_front());
                end
                if (!if_req && if_pend.size() > 0) begin
                    if_req = 1'b1; if_addr = if_pend[0];
                end
                if (!d_req && d_pend.size() > 0) begin
                    d_req = 1'b1; d_we = d_pend[0].we;
                    d_addr = d_pend[0].addr; d_wdata = d_pend[0].wdata;
                end
            end
        end
    end

    // ---------------- scoreboard model ----------------
    typedef struct { bit port; logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] model_wr [logic [31:0]];

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_wr.exists(a) ? model_wr[a] : pat(a);
    endfunction

    task automatic expect_if(input logic [31:0] a);
        exp_t e;
        e.port = 1'b0; e.we = 1'b0; e.addr = a; e.wdata = '0; e.rdata = model_rd(a);
        exp_q.push_back(e);
    endtask

    task automatic expect_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        e.port = 1'b1; e.we = we; e.addr = a; e.wdata = wd; e.rdata = model_rd(a);
        if (we) model_wr[a] = wd;
        exp_q.push_back(e);
    endtask

    task automatic push_if(input logic [31:0] a);
        expect_if(a);
        if_pend.push_back(a);
    endtask

    task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        dreq_t r;
        r.we = we; r.addr = a; r.wdata = wd;
        expect_d(we, a, wd);
        d_pend.push_back(r);
    endtask

    // Per-cycle compare against the model.
    logic [31:0] exp_ifr = '0, exp_dr = '0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    logic        p_mreq = 1'b0, p_rdy = 1'b0, p_we = 1'b0, p_ifv = 1'b0, p_dv = 1'b0;

    initial begin
        exp_t h;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk1("rst_m_req", m_req, 1'b0);
                chk1("rst_valid", if_valid | d_valid, 1'b0);
                chk32("rst_if_rdata", if_rdata, 32'h0);
                chk32("rst_d_rdata", d_rdata, 32'h0);
                chk32("rst_m_addr", m_addr, 32'h0);
                exp_ifr = '0; exp_dr = '0;
                p_mreq = 1'b0; p_rdy = 1'b0; p_ifv = 1'b0; p_dv = 1'b0;
                continue;
            end
            chk1("if_stall", if_stall, if_req && !if_valid);
            chk1("d_stall", d_stall, d_req && !d_valid);
            if (p_mreq && !p_rdy) begin
                chk1("hold_m_req", m_req, 1'b1);
                chk32("hold_m_addr", m_addr, p_addr);
                chk1("hold_m_we", m_we, p_we);
                chk32("hold_m_wdata", m_wdata, p_wdata);
            end
            if (m_req && !p_mreq) begin
                if (exp_q.size() == 0) failm("unexpected_m_req");
                else begin
                    chk32("issue_m_addr", m_addr, exp_q[0].addr);
                    chk1("issue_m_we", m_we, exp_q[0].we);
                    if (exp_q[0].we) chk32("issue_m_wdata", m_wdata, exp_q[0].wdata);
                end
            end
            if (if_valid || d_valid) begin
                chk1("single_port_valid", if_valid && d_valid, 1'b0);
                chk1("valid_one_cycle", (if_valid && p_ifv) || (d_valid && p_dv), 1'b0);
                if (exp_q.size() == 0) failm("spurious_valid");
                else begin
                    h = exp_q.pop_front();
                    chk1("valid_port", d_valid, h.port);
                    if (!h.we) begin
                        if (h.port) exp_dr = h.rdata;
                        else        exp_ifr = h.rdata;
                    end
                end
            end
            chk32("if_rdata", if_rdata, exp_ifr);
            chk32("d_rdata", d_rdata, exp_dr);
            p_mreq = m_req; p_rdy = m_ready; p_we = m_we;
            p_addr = m_addr; p_wdata = m_wdata;
            p_ifv = if_valid; p_dv = d_valid;
        end
    end

    task automatic wait_idle(input string name, input int bound);
        int i = 0;
        while ((exp_q.size() != 0 || if_pend.size() != 0 || d_pend.size() != 0) && i < bound) begin
            @(negedge clk);
            i++;
        end
        if (exp_q.size() != 0 || if_pend.size() != 0 || d_pend.size() != 0) failm(name);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int i;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk1("reset_m_we", m_we, 1'b0);
        chk32("reset_m_wdata", m_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // IF read alone, zero-wait memory
        set_mem(0, 0);
        push_if(32'h4);
        @(negedge clk);
        chk1("t1_c0_stall", if_stall, 1'b1);
        chk1("t1_c0_m_req", m_req, 1'b0);
        @(negedge clk);
        chk1("t1_c1_m_req", m_req, 1'b1);
        chk32("t1_c1_m_addr", m_addr, 32'h4);
        chk1("t1_c1_m_we", m_we, 1'b0);
        chk1("t1_c1_stall", if_stall, 1'b1);
        @(negedge clk);
        chk1("t1_c2_valid", if_valid, 1'b1);
        chk32("t1_c2_rdata", if_rdata, 32'h0041_0820);
        chk1("t1_c2_stall", if_stall, 1'b0);
        @(negedge clk);
        chk1("t1_c3_valid", if_valid, 1'b0);
        chk1("t1_c3_stall", if_stall, 1'b0);
        wait_idle("t1_timeout", 20);

        // Store with 3 cycles of back-pressure
        set_mem(3, 0);
        push_d(1'b1, 32'h100, 32'hDEAD_BEEF);
        @(negedge clk);
        chk1("t2_c0_stall", d_stall, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk1("t2_m_req", m_req, 1'b1);
            chk1("t2_m_we", m_we, 1'b1);
            chk32("t2_m_wdata", m_wdata, 32'hDEAD_BEEF);
            chk1("t2_m_ready", m_ready, c == 4);
            chk1("t2_no_valid_yet", d_valid, 1'b0);
        end
        @(negedge clk);
        chk1("t2_c5_valid", d_valid, 1'b1);
        chk32("t2_c5_rdata_kept", d_rdata, 32'h0);
        wait_idle("t2_timeout", 20);
        set_mem(0, 0);
        push_d(1'b0, 32'h100, 32'h0);
        wait_idle("t2_rb_timeout", 20);
        chk32("t2_readback", d_rdata, 32'hDEAD_BEEF);

        // Read latency: m_rvalid 4 cycles after accept
        set_mem(0, 4);
        push_d(1'b0, 32'h40, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk1("t3_c1_accept", m_req && m_ready, 1'b1);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            chk1("t3_wait_no_valid", d_valid, 1'b0);
            chk1("t3_wait_m_req", m_req, 1'b0);
        end
        chk1("t3_c5_rvalid", m_rvalid, 1'b1);
        @(negedge clk);
        chk1("t3_c6_valid", d_valid, 1'b1);
        chk32("t3_c6_rdata", d_rdata, 32'h0410_8200);
        wait_idle("t3_timeout", 20);
        spurious = 1;
        repeat (2) @(negedge clk);
        chk1("t3_spurious_no_valid", if_valid | d_valid, 1'b0);
        chk32("t3_spurious_rdata_kept", d_rdata, 32'h0410_8200);

        // Conflict: two back-to-back requests per port
        set_mem(0, 0);
        do_reset();
        @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
        expect_if(32'h8); expect_d(1'b0, 32'h200, 32'h0);
        expect_if(32'hC); expect_d(1'b0, 32'h204, 32'h0);
`else
        expect_d(1'b0, 32'h200, 32'h0); expect_d(1'b0, 32'h204, 32'h0);
        expect_if(32'h8); expect_if(32'hC);
`endif
        if_pend.push_back(32'h8); if_pend.push_back(32'hC);
        begin
            dreq_t r;
            r.we = 1'b0; r.wdata = '0;
            r.addr = 32'h200; d_pend.push_back(r);
            r.addr = 32'h204; d_pend.push_back(r);
        end
        i = 0;
        while (!(if_valid || d_valid) && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk1("t4_first_winner_is_d", d_valid, FIRST_D);
        wait_idle("t4_timeout", 60);

        // Reset while waiting for read data
        set_mem(0, 8);
        push_if(32'h10);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk1("t5_rst_m_req", m_req, 1'b0);
        chk1("t5_rst_if_valid", if_valid, 1'b0);
        chk32("t5_rst_if_rdata", if_rdata, 32'h0);
        chk32("t5_rst_d_rdata", d_rdata, 32'h0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk1("t5_late_rvalid_ignored", if_valid | d_valid, 1'b0);
        set_mem(0, 0);
        push_if(32'h14);
        wait_idle("t5_timeout", 20);
        chk32("t5_after_reset_fetch", if_rdata, 32'h0145_28A0);

        chk32("final_scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
